// File: rtl/ec_pkg.sv
// ec_pkg: default field constants, slope FSM states and modular add/sub/double helpers.
package ec_pkg;
    localparam int EC_W = 8;
    localparam logic [EC_W-1:0] EC_P = 8'd251;
    localparam logic [EC_W-1:0] EC_A = 8'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_DSQ, S_DFIX, S_EXP_SQ, S_EXP_MUL, S_FINAL, S_DONE
    } state_t;

    // Operands are < p, so one conditional subtract is enough.
    function automatic logic [EC_W-1:0] mod_add(input logic [EC_W-1:0] a, b, p);
        logic [EC_W:0] sum, dif;
        sum = {1'b0, a} + {1'b0, b};
        dif = sum - {1'b0, p};
        return dif[EC_W] ? sum[EC_W-1:0] : dif[EC_W-1:0];
    endfunction

    function automatic logic [EC_W-1:0] mod_sub(input logic [EC_W-1:0] a, b, p);
        logic [EC_W:0] dif;
        dif = {1'b0, a} - {1'b0, b};
        return dif[EC_W] ? dif[EC_W-1:0] + p : dif[EC_W-1:0];
    endfunction

    function automatic logic [EC_W-1:0] mod_dbl(input logic [EC_W-1:0] a, p);
        return mod_add(a, a, p);
    endfunction
endpackage

// File: rtl/ec_slope_calc_mod_mul.sv
// mod_mul: bit-serial interleaved modular multiplier; one issue cycle plus W double-and-add steps.
module mod_mul
    import ec_pkg::*;
#(
    parameter int W = EC_W,
    parameter logic [W-1:0] P = EC_P
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] p
);
    localparam int CW = $clog2(W + 1);
    logic [W-1:0] a_r, b_r, acc, acc2;
    logic [CW-1:0] cnt;

    // p is the value the accumulator takes at the next edge, so the caller can capture it on done.
    assign acc2 = mod_dbl(acc, P);
    assign p = b_r[W-1] ? mod_add(acc2, a_r, P) : acc2;
    assign busy = cnt != '0;
    assign done = cnt == CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (go) begin
            a_r <= a;
            b_r <= b;
            acc <= '0;
            cnt <= CW'(W);
        end else if (busy) begin
            acc <= p;
            b_r <= b_r << 1;
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/ec_slope_calc.sv
// ec_slope_calc: chord/tangent slope mod P, inverting the denominator by Fermat on one serial multiplier.
// Define SLOPE_CONST_TIME_EN to run the exponent multiply on every bit and discard it when the bit is 0.
module ec_slope_calc
    import ec_pkg::*;
#(
    parameter int W = EC_W,
    parameter logic [W-1:0] P = EC_P,
    parameter logic [W-1:0] A = EC_A
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         dbl,
    input  logic [W-1:0] ax,
    input  logic [W-1:0] ay,
    input  logic [W-1:0] bx,
    input  logic [W-1:0] by,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] s,
    output logic         err
);
`ifdef SLOPE_CONST_TIME_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif
    localparam logic [W-1:0] E = P - W'(2);
    localparam int BW = $clog2(W);

    state_t state, nxt;
    logic [W-1:0] ax_r, ay_r, bx_r, by_r, num, den, r, t, den_c, mm_a, mm_b, mm_p;
    logic dbl_r, mm_go, mm_busy, mm_done, ebit, last;
    logic [BW-1:0] bi;

    assign den_c = dbl_r ? mod_dbl(ay_r, P) : mod_sub(bx_r, ax_r, P);
    assign ebit = E[bi];
    assign last = bi == '0;

    mod_mul #(.W(W), .P(P)) u_mul (
        .clk(clk), .rst_n(rst_n), .go(mm_go), .a(mm_a), .b(mm_b),
        .busy(mm_busy), .done(mm_done), .p(mm_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    nxt = start ? S_PREP : S_IDLE;
            S_PREP:    nxt = den_c == '0 ? S_DONE : dbl_r ? S_DSQ : S_EXP_SQ;
            S_DSQ:     nxt = mm_done ? S_DFIX : S_DSQ;
            S_DFIX:    nxt = S_EXP_SQ;
            S_EXP_SQ:  nxt = !mm_done ? S_EXP_SQ : (CT || ebit) ? S_EXP_MUL : last ? S_FINAL : S_EXP_SQ;
            S_EXP_MUL: nxt = !mm_done ? S_EXP_MUL : last ? S_FINAL : S_EXP_SQ;
            S_FINAL:   nxt = mm_done ? S_DONE : S_FINAL;
            default:   nxt = S_IDLE;
        endcase
    end

    // Every multiply state issues once, in its first cycle, while the multiplier is idle.
    always_comb begin
        busy = state != S_IDLE && state != S_DONE;
        done = state == S_DONE;
        mm_go = (state inside {S_DSQ, S_EXP_SQ, S_EXP_MUL, S_FINAL}) && !mm_busy;
        mm_a = state == S_DSQ ? ax_r : state == S_FINAL ? num : r;
        mm_b = state == S_DSQ ? ax_r : state == S_EXP_MUL ? den : r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {ax_r, ay_r, bx_r, by_r, num, den, r, t, s} <= '0;
            dbl_r <= 1'b0;
            err <= 1'b0;
            bi <= '0;
        end else if (state == S_IDLE && start) begin
            {ax_r, ay_r, bx_r, by_r} <= {ax, ay, bx, by};
            dbl_r <= dbl;
        end else if (state == S_PREP) begin
            num <= mod_sub(by_r, ay_r, P);
            den <= den_c;
            r <= W'(1);
            bi <= BW'(W - 1);
            if (den_c == '0) begin
                s <= '0;
                err <= 1'b1;
            end
        end else if (state == S_DSQ && mm_done) begin
            t <= mm_p;
        end else if (state == S_DFIX) begin
            num <= mod_add(mod_add(mod_dbl(t, P), t, P), A, P);
        end else if (state == S_EXP_SQ && mm_done) begin
            r <= mm_p;
            if (!CT && !ebit) bi <= bi - 1'b1;
        end else if (state == S_EXP_MUL && mm_done) begin
            if (ebit) r <= mm_p;
            bi <= bi - 1'b1;
        end else if (state == S_FINAL && mm_done) begin
            s <= mm_p;
            err <= 1'b0;
        end
    end
endmodule

// File: doc/ec_slope_calc.md
# ec_slope_calc

Sequential slope generator for the EC point datapath. It computes the chord slope s = (By−Ay)/(Bx−Ax) mod P for point addition, or the tangent slope s = (3·Ax²+A)/(2·Ay) mod P for doubling. The resulting s is the input the point-result stage consumes to form x3 and y3. Inversion uses Fermat exponentiation (den^(P−2)) on a shared bit-serial modular multiplier.

## Interface
- W, 8, field/coordinate width
- P, 8'd251, odd prime modulus, 2 < P < 2^W
- A, 0, curve coefficient a (must be < P)
- Clk  in  1  single clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when busy=0
- dbl  in  1  1 = tangent (doubling) slope, 0 = chord (addition) slope; sampled with start
- Ax, Ay, Bx, By  in  W each  affine coordinates, each < P; sampled with start
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse; s/err valid on this cycle and held until next accept
- s  out  W  slope mod P
- err  out  1  denominator was zero (vertical chord / 2-torsion point); s=0

## Operation
- Reset values: busy=0, done=0, s=0, err=0, FSM=IDLE.
- FSM: IDLE → PREP → [DSQ → DFIX] (dbl only) → EXP_SQ ⇄ EXP_MUL → FINAL → DONE → IDLE.
- PREP (1 cycle):
  - add: num=(By−Ay) mod P, den=(Bx−Ax) mod P. Compute with a W+1-bit subtract plus conditional +P.
  - dbl: den=(2·Ay) mod P.
  - r=1.
  - If den==0: go to DONE with err=1, s=0, no multiplies.
- DSQ: t=Ax·Ax mod P. DFIX (1 cycle): num=(3t+A) mod P, using successive conditional subtracts of P.
- Exponent E=P−2, scanned MSB→LSB over W bits. Each bit:
  - EXP_SQ: r=r·r.
  - EXP_MUL: r=r·den if E bit set.
- FINAL: s=num·r mod P.
- DONE: done pulse, busy drops in the same cycle, FSM returns to IDLE.
- Modular multiply takes exactly M=W+1 cycles per operation: 1 issue cycle plus W double-and-add iterations. Every intermediate value stays < P.
- start while busy is ignored; there is no queue.
- Reset_n low at any point aborts the operation and restores all reset values. No done pulse is produced for the aborted operation.

## Timing
- Latency is counted from the start-accept cycle to the done cycle. The figures below assume SLOPE_CONST_TIME_EN.
  - add: 2 + (2W+1)·M. With W=8: 155 cycles.
  - dbl: add latency + M + 1. With W=8: 165 cycles.
  - err (den==0): 2 cycles.
- Earliest next accept: the cycle after done.
- s and err are registered and change only on the done cycle or on reset.

## Configuration
- SLOPE_CONST_TIME_EN defined:
  - EXP_MUL executes on every bit. The product is discarded when the E bit is 0.
  - Latency is independent of P's bit pattern, as listed above.
- Undefined:
  - EXP_MUL is skipped on E bits equal to 0.
  - add latency = 2 + (W + popcount(P−2) + 1)·M. With P=251: 137 cycles.
  - Results are identical in both configurations.

## Structure
- Package ec_pkg holds:
  - default W, P, A constants
  - the FSM state enum
  - the modular add/sub/double helper functions
- Sub-module mod_mul(Clk, Reset_n, go, a, b, busy, done, p):
  - bit-serial interleaved multiply, M cycles
  - a single instance is time-shared across all multiply steps
- Top level holds: FSM, num/den/r/t registers, exponent bit counter.

## Test plan
- Add: A=(2,3), B=(5,9), P=251 → s=2, err=0, done exactly 155 cycles after accept.
- Wrap: A=(3,10), B=(1,3) → num=244, den=249, s=129.
- Doubling: dbl=1, Ax=1, Ay=1, A=0 → s=127, done at 165 cycles.
- Degenerate: Ax=Bx=7, Ay=1, By=5 → err=1, s=0, done 2 cycles after accept. Also dbl=1 with Ay=0 → err=1.
- Busy/abort:
  - Pulse start at cycle 10 of an operation → ignored, first result unchanged.
  - Drop Reset_n mid-exponent → busy=0, s=0, no done.
  - A new start after reset completes correctly.
- Configuration: rerun the add vector without SLOPE_CONST_TIME_EN → s=2, done at 137 cycles.
